// File: rtl/reg_file.sv
// Architectural register file: 2^ADDR_W x DATA_W, two async read ports, one sync write port, x0 reads zero.
// Optional write-through bypass on rd1/rd2 when REGFILE_BYPASS_EN is defined (dbg_data is never bypassed).

module reg_file_entry #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  q <= '0;
    else if (en) q <= d;
  end
endmodule

module reg_file #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);
  localparam int DEPTH = 1 << ADDR_W;

  logic [DEPTH-1:0][DATA_W-1:0] regs;

  // Entry 0 has no storage; the constant makes every read of index 0 return zero.
  assign regs[0] = '0;

  genvar i;
  generate
    for (i = 1; i < DEPTH; i++) begin : g_ent
      reg_file_entry #(.DATA_W(DATA_W)) u_ent (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (we && (wa == ADDR_W'(i))),
        .d     (wd),
        .q     (regs[i])
      );
    end
  endgenerate

  assign dbg_data = regs[dbg_addr];

`ifdef REGFILE_BYPASS_EN
  logic wr_live;
  // Held reset must win over a pending write, so bypass is gated by rst_n.
  assign wr_live = rst_n && we && (wa != '0);
  assign rd1 = (wr_live && (ra1 == wa)) ? wd : regs[ra1];
  assign rd2 = (wr_live && (ra2 == wa)) ? wd : regs[ra2];
`else
  assign rd1 = regs[ra1];
  assign rd2 = regs[ra2];
`endif

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed vector table, corner sequences and a randomized
// run against an array-based reference model. Honors REGFILE_BYPASS_EN when defined.

module tb_reg_file;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk, rst_n, we;
  logic [4:0]  ra1, ra2, wa, dbg_addr;
  logic [31:0] wd, rd1, rd2, dbg_data;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] mdl [32];

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [31:0] e1;
    logic [31:0] e2;
  } vec_t;

  vec_t tbl [8];

  reg_file #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ra1      (ra1),
    .ra2      (ra2),
    .rd1      (rd1),
    .rd2      (rd2),
    .we       (we),
    .wa       (wa),
    .wd       (wd),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] mdl_rd(input logic [4:0] a);
    return (a == 5'd0) ? 32'h0 : mdl[a];
  endfunction

  // Value a read port should show before the edge, given the current write request.
  function automatic logic [31:0] port_exp(input logic [4:0] a);
    if (BYP && rst_n && we && wa != 5'd0 && a == wa) return wd;
    return mdl_rd(a);
  endfunction

  task automatic sweep_zero(input string nm);
    for (int k = 0; k < 32; k++) begin
      dbg_addr = 5'(k);
      #1;
      chk(nm, dbg_data, 32'h0);
    end
  endtask

  initial begin
    rst_n = 1'b0; we = 1'b0; wa = '0; wd = '0; ra1 = '0; ra2 = '0; dbg_addr = '0;
    for (int k = 0; k < 32; k++) mdl[k] = '0;

    tbl[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 5'd5, 5'd0,  32'hDEADBEEF, 32'h0};
    tbl[1] = '{1'b1, 5'd31, 32'h00000010, 5'd5, 5'd31, 32'hDEADBEEF, 32'h00000010};
    tbl[2] = '{1'b1, 5'd0,  32'hFFFFFFFF, 5'd0, 5'd5,  32'h0,        32'hDEADBEEF};
    tbl[3] = '{1'b0, 5'd7,  32'h12345678, 5'd7, 5'd31, 32'h0,        32'h00000010};
    tbl[4] = '{1'b1, 5'd9,  32'h00000001, 5'd9, 5'd9,  32'h00000001, 32'h00000001};
    tbl[5] = '{1'b1, 5'd1,  32'hA5A5A5A5, 5'd1, 5'd2,  32'hA5A5A5A5, 32'h0};
    tbl[6] = '{1'b1, 5'd5,  32'h00000000, 5'd5, 5'd1,  32'h0,        32'hA5A5A5A5};
    tbl[7] = '{1'b0, 5'd1,  32'h0BADF00D, 5'd1, 5'd31, 32'hA5A5A5A5, 32'h00000010};

    // Reset held from time 0; a live write request must not leak through.
    #1;
    we = 1'b1; wa = 5'd4; wd = 32'hCAFEF00D; ra1 = 5'd4; ra2 = 5'd4;
    #1;
    chk("reset_rd1", rd1, 32'h0);
    chk("reset_rd2", rd2, 32'h0);
    sweep_zero("reset_sweep");
    @(posedge clk); #1;
    chk("reset_hold_edge", rd1, 32'h0);

    @(negedge clk);
    we = 1'b0;
    rst_n = 1'b1;

    foreach (tbl[v]) begin
      @(negedge clk);
      we = tbl[v].we; wa = tbl[v].wa; wd = tbl[v].wd; ra1 = tbl[v].ra1; ra2 = tbl[v].ra2;
      @(posedge clk);
      if (tbl[v].we && tbl[v].wa != 5'd0) mdl[tbl[v].wa] = tbl[v].wd;
      #1;
      we = 1'b0;
      #1;
      chk($sformatf("tbl%0d_rd1", v), rd1, tbl[v].e1);
      chk($sformatf("tbl%0d_rd2", v), rd2, tbl[v].e2);
    end

    // No entry disturbed beyond the model (covers the discarded x0 write).
    for (int k = 0; k < 32; k++) begin
      dbg_addr = 5'(k);
      #1;
      chk($sformatf("sweep_x%0d", k), dbg_data, mdl_rd(5'(k)));
    end

    // Same-cycle RAW on x9 (holds 1).
    @(negedge clk);
    we = 1'b1; wa = 5'd9; wd = 32'h2; ra1 = 5'd9; ra2 = 5'd9; dbg_addr = 5'd9;
    #1;
    chk("raw_pre_rd1", rd1, BYP ? 32'h2 : 32'h1);
    chk("raw_pre_rd2", rd2, BYP ? 32'h2 : 32'h1);
    chk("raw_pre_dbg", dbg_data, 32'h1);
    @(posedge clk);
    mdl[9] = 32'h2;
    #1;
    we = 1'b0;
    #1;
    chk("raw_post_rd1", rd1, 32'h2);
    chk("raw_post_rd2", rd2, 32'h2);

    // Write aimed at x0 never bypasses.
    @(negedge clk);
    we = 1'b1; wa = 5'd0; wd = 32'hFFFFFFFF; ra1 = 5'd0; ra2 = 5'd0;
    #1;
    chk("x0_pre_rd1", rd1, 32'h0);
    @(posedge clk); #1;
    we = 1'b0;
    #1;
    chk("x0_post_rd2", rd2, 32'h0);

    // Randomized traffic against the model.
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      we = 1'($urandom); wa = 5'($urandom); wd = $urandom;
      ra1 = 5'($urandom); ra2 = 5'($urandom); dbg_addr = 5'($urandom);
      if ($urandom_range(0, 3) == 0) ra1 = wa;
      if ($urandom_range(0, 3) == 0) ra2 = wa;
      if ($urandom_range(0, 7) == 0) dbg_addr = wa;
      #1;
      chk("rnd_rd1", rd1, port_exp(ra1));
      chk("rnd_rd2", rd2, port_exp(ra2));
      chk("rnd_dbg", dbg_data, mdl_rd(dbg_addr));
      @(posedge clk);
      if (we && wa != 5'd0) mdl[wa] = wd;
    end

    // Make sure x3 is nonzero, then collide a write with an async reset mid-cycle.
    @(negedge clk);
    we = 1'b1; wa = 5'd3; wd = 32'h13572468;
    @(posedge clk); #1;
    we = 1'b0; ra1 = 5'd3;
    #1;
    chk("pre_coll_x3", rd1, 32'h13572468);
    @(negedge clk);
    we = 1'b1; wa = 5'd3; wd = 32'hAAAA5555; ra1 = 5'd3; ra2 = 5'd3;
    #2;
    rst_n = 1'b0;
    #1;
    chk("coll_rd1", rd1, 32'h0);
    chk("coll_rd2", rd2, 32'h0);
    sweep_zero("coll_sweep");
    for (int k = 0; k < 32; k++) mdl[k] = '0;
    @(posedge clk);
    @(negedge clk);
    we = 1'b0;
    rst_n = 1'b1;
    #1;
    chk("post_rel_x3", rd1, 32'h0);
    dbg_addr = 5'd3;
    #1;
    chk("post_rel_dbg3", dbg_data, 32'h0);

    // First edge after release accepts a write.
    we = 1'b1; wa = 5'd3; wd = 32'h00000077;
    @(posedge clk); #1;
    we = 1'b0;
    #1;
    chk("first_wr_rd1", rd1, 32'h00000077);
    chk("first_wr_dbg", dbg_data, 32'h00000077);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
